coin_pulse_conditioner: RTL and testbench
=========================================

Name: coin_pulse_conditioner

Overview:
- Front-end stage of the vending coin path.
- Takes raw, asynchronous, bouncy coin-sensor levels for dime and nickel.
- Emits clean single-cycle, mutually exclusive, rate-limited pulses that drive the D and N inputs of the coin-accumulator FSM directly downstream.
- Flags coin events lost to overrun.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized cycles a level change must hold before acceptance (>=1).
- GAP_CYCLES, 2, minimum idle cycles between any two output pulses (>=0).
- CNT_W, 8, width of the debounce and gap counters. Must hold max(DEBOUNCE_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock; all flops posedge.
- reset  input  1  synchronous, active-high reset.
- raw_dime  input  1  asynchronous dime sensor level.
- raw_nickel  input  1  asynchronous nickel sensor level.
- ovr_clr  input  1  synchronous clear of overrun.
- dime_pulse  output  1  one-cycle dime event; feeds accumulator D.
- nickel_pulse  output  1  one-cycle nickel event; feeds accumulator N.
- overrun  output  1  sticky: a coin event was dropped.
- busy  output  1  any pending event or gap counter nonzero.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset: sync chains, debounced levels, debounce counters, pending flags, gap counter, dime_pulse, nickel_pulse, overrun and busy all 0.
- Debounced levels reset to 0, so a raw input held high through reset yields exactly one pulse after release.
- Sync: each raw input passes a 2-flop synchronizer giving s_x.
- Debounce, per channel, with debounced level db_x and counter c_x:
  - If s_x == db_x: c_x <= 0.
  - Else if c_x == DEBOUNCE_CYCLES-1: db_x <= s_x and c_x <= 0.
  - Else: c_x <= c_x+1.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized cycles are rejected.
- Event: the edge on which db_x flips 0->1 sets pend_x.
  - A 1->0 flip produces no event.
- Arbiter, two states:
  - ISSUE (gap==0): if pend_d, register dime_pulse=1, clear pend_d and load gap<=GAP_CYCLES. Otherwise, if pend_n, do the same for nickel_pulse. Otherwise both pulses are 0.
  - WAIT (gap>0): pulses 0 and gap decrements by 1 each edge.
  - With GAP_CYCLES=0, pulses may issue on consecutive edges.
- Pulses are registered, high for exactly one cycle, and never both high in the same cycle.
- Dime has fixed priority on simultaneous pending events.
- Latency: a raw rise first sampled at edge 1 gives a pulse high after edge DEBOUNCE_CYCLES+3, provided the arbiter is idle.
- Spacing: consecutive pulses are separated by GAP_CYCLES+1 edges (pulse edge to pulse edge).
- Overrun:
  - Condition: a new event on channel x while pend_x is already set and not being issued on that same edge.
  - Effect: overrun <= 1 and the new event is dropped.
  - Issue coinciding with a new event: pend_x stays set, no overrun.
  - ovr_clr clears overrun; a simultaneous new overrun wins (overrun stays 1).
- busy = pend_d | pend_n | (gap != 0), registered-state derived.
- Reset mid-operation discards pending events and the gap count; no pulse appears on the edge after reset deasserts.

Test Plan:
- Clean dime: raw_dime 0->1 held 20 cycles, DEBOUNCE=4, GAP=2 -> dime_pulse high exactly one cycle, after edge 7; nickel_pulse stays 0; no second pulse on release.
- Bounce: raw_nickel toggles high 3 cycles, low 2 cycles, repeated 4 times, then low -> no nickel_pulse, busy stays 0; then held high 6 cycles -> one nickel_pulse.
- Simultaneous: both raw inputs rise on the same cycle -> dime_pulse after edge 7, nickel_pulse after edge 10, overrun 0.
- Overrun: GAP=8; dime, then nickel, then a second nickel debounced before the first nickel issues -> pulses D then N only (second nickel dropped), overrun=1; ovr_clr pulse -> overrun=0.
- Reset: raw_dime high during reset -> one dime_pulse 7 edges after release. Separately, assert reset while pend_n=1 -> no nickel_pulse, busy=0.
- Back-to-back with GAP=0: dime and nickel pending together -> pulses on consecutive edges, never overlapping.

Source files
------------

// File: rtl/coin_pulse_conditioner.sv
// coin_pulse_conditioner: synchronizes, debounces and arbitrates dime/nickel sensor levels into spaced one-cycle pulses
module coin_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_dime,
  input  logic raw_nickel,
  input  logic ovr_clr,
  output logic dime_pulse,
  output logic nickel_pulse,
  output logic overrun,
  output logic busy
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES);
  logic [1:0] raw, rise, pend, iss;
  logic [CNT_W-1:0] gap;
  logic ovr_set;
  assign raw = {raw_nickel, raw_dime};
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic s1, s, db, flip;
    logic [CNT_W-1:0] c;
    assign flip = (s != db) && (c == DB_LAST);
    assign rise[i] = flip && s;
    always_ff @(posedge clk)
      if (reset) begin
        s1 <= 1'b0;
        s <= 1'b0;
        db <= 1'b0;
        c <= '0;
      end else begin
        s1 <= raw[i];
        s <= s1;
        c <= (s == db || flip) ? '0 : c + CNT_W'(1);
        if (flip) db <= s;
      end
  end
  // gap == 0 is the issue state; dime wins when both are pending
  assign iss[0] = (gap == '0) && pend[0];
  assign iss[1] = (gap == '0) && !pend[0] && pend[1];
  assign ovr_set = |(rise & pend & ~iss);
  assign busy = (|pend) || (gap != '0);
  always_ff @(posedge clk)
    if (reset) begin
      pend <= '0;
      gap <= '0;
      dime_pulse <= 1'b0;
      nickel_pulse <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pend <= (pend & ~iss) | rise;
      dime_pulse <= iss[0];
      nickel_pulse <= iss[1];
      gap <= (|iss) ? GAP_LD : (gap != '0 ? gap - CNT_W'(1) : '0);
      overrun <= ovr_set || (overrun && !ovr_clr);
    end
endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// tb_coin_pulse_conditioner: three parameterizations checked against a sample-history/timestamp reference model
module tb_coin_pulse_conditioner;
  localparam int N = 3;
  localparam int DEB [N] = '{4, 2, 1};
  localparam int GAP [N] = '{2, 8, 0};
  logic clk = 1'b0;
  logic reset, raw_dime, raw_nickel, ovr_clr;
  logic [N-1:0] dp, np, ov, bz;
  always #5 clk = ~clk;

  coin_pulse_conditioner #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .raw_dime(raw_dime), .raw_nickel(raw_nickel), .ovr_clr(ovr_clr),
    .dime_pulse(dp[0]), .nickel_pulse(np[0]), .overrun(ov[0]), .busy(bz[0]));
  coin_pulse_conditioner #(.DEBOUNCE_CYCLES(2), .GAP_CYCLES(8), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .raw_dime(raw_dime), .raw_nickel(raw_nickel), .ovr_clr(ovr_clr),
    .dime_pulse(dp[1]), .nickel_pulse(np[1]), .overrun(ov[1]), .busy(bz[1]));
  coin_pulse_conditioner #(.DEBOUNCE_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .raw_dime(raw_dime), .raw_nickel(raw_nickel), .ovr_clr(ovr_clr),
    .dime_pulse(dp[2]), .nickel_pulse(np[2]), .overrun(ov[2]), .busy(bz[2]));

  logic m_s1 [N][2], m_s [N][2], m_db [N][2], m_pend [N][2];
  logic m_h [N][2][16];
  int m_last [N];
  logic [N-1:0] m_dp, m_np, m_ov, m_bz;
  int cyc = 0, e = 0, nchk = 0, nbad = 0;
  int first_d [N], first_n [N], cnt_d [N], cnt_n [N], bz_any [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // a level is accepted once the last DEB synchronized samples all disagree with it
  task automatic model_step(input int i, input logic rd, input logic rn, input logic rst, input logic oc);
    logic raw [2];
    logic ev [2];
    logic iss [2];
    logic all, can, ovs;
    raw[0] = rd;
    raw[1] = rn;
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_s1[i][ch] = 1'b0; m_s[i][ch] = 1'b0; m_db[i][ch] = 1'b0; m_pend[i][ch] = 1'b0;
        for (int j = 0; j < 16; j++) m_h[i][ch][j] = 1'b0;
      end
      m_last[i] = -1000;
      m_dp[i] = 1'b0; m_np[i] = 1'b0; m_ov[i] = 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int j = 15; j > 0; j--) m_h[i][ch][j] = m_h[i][ch][j-1];
        m_h[i][ch][0] = m_s[i][ch];
        all = 1'b1;
        for (int j = 0; j < DEB[i]; j++) if (m_h[i][ch][j] === m_db[i][ch]) all = 1'b0;
        ev[ch] = all && !m_db[i][ch];
        if (all) m_db[i][ch] = !m_db[i][ch];
      end
      can = (cyc - m_last[i]) > GAP[i];
      iss[0] = can && m_pend[i][0];
      iss[1] = can && !m_pend[i][0] && m_pend[i][1];
      ovs = (ev[0] && m_pend[i][0] && !iss[0]) || (ev[1] && m_pend[i][1] && !iss[1]);
      for (int ch = 0; ch < 2; ch++) m_pend[i][ch] = ev[ch] || (m_pend[i][ch] && !iss[ch]);
      if (iss[0] || iss[1]) m_last[i] = cyc;
      m_dp[i] = iss[0];
      m_np[i] = iss[1];
      m_ov[i] = ovs || (m_ov[i] && !oc);
      for (int ch = 0; ch < 2; ch++) begin
        m_s[i][ch] = m_s1[i][ch];
        m_s1[i][ch] = raw[ch];
      end
    end
    m_bz[i] = m_pend[i][0] || m_pend[i][1] || ((cyc - m_last[i]) < GAP[i]);
  endtask

  task automatic tick(input logic rd, input logic rn, input logic rst, input logic oc);
    raw_dime = rd; raw_nickel = rn; reset = rst; ovr_clr = oc;
    @(posedge clk);
    cyc++;
    e++;
    for (int i = 0; i < N; i++) model_step(i, rd, rn, rst, oc);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.dime_pulse", i), 32'(dp[i]), 32'(m_dp[i]));
      chk($sformatf("u%0d.nickel_pulse", i), 32'(np[i]), 32'(m_np[i]));
      chk($sformatf("u%0d.overrun", i), 32'(ov[i]), 32'(m_ov[i]));
      chk($sformatf("u%0d.busy", i), 32'(bz[i]), 32'(m_bz[i]));
      chk($sformatf("u%0d.exclusive", i), 32'(dp[i] & np[i]), 32'd0);
      if (dp[i] === 1'b1) begin cnt_d[i]++; if (first_d[i] < 0) first_d[i] = e; end
      if (np[i] === 1'b1) begin cnt_n[i]++; if (first_n[i] < 0) first_n[i] = e; end
      if (bz[i] === 1'b1) bz_any[i]++;
    end
  endtask

  task automatic clr_stats();
    e = 0;
    for (int i = 0; i < N; i++) begin
      first_d[i] = -1; first_n[i] = -1; cnt_d[i] = 0; cnt_n[i] = 0; bz_any[i] = 0;
    end
  endtask

  task automatic do_reset();
    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++)
      chk($sformatf("u%0d.reset_state", i), 32'({dp[i], np[i], ov[i], bz[i]}), 32'd0);
    clr_stats();
  endtask

  initial begin
    int hd, hn;
    logic rd, rn;
    do_reset();
    // clean dime: pulse after edge DEB+3, once, nothing on release
    repeat (20) tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (15) tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.clean_latency", i), first_d[i], DEB[i] + 3);
      chk($sformatf("u%0d.clean_dcount", i), cnt_d[i], 1);
      chk($sformatf("u%0d.clean_ncount", i), cnt_n[i], 0);
    end
    // bounce shorter than 4 cycles rejected by u0
    do_reset();
    repeat (4) begin
      repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("u0.bounce_ncount", cnt_n[0], 0);
    chk("u0.bounce_busy", bz_any[0], 0);
    clr_stats();
    repeat (6) tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (15) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("u0.held_ncount", cnt_n[0], 1);
    // simultaneous rise: dime first, nickel GAP+1 edges later
    do_reset();
    repeat (20) tick(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.simul_d", i), first_d[i], DEB[i] + 3);
      chk($sformatf("u%0d.simul_n", i), first_n[i], DEB[i] + 3 + GAP[i] + 1);
      chk($sformatf("u%0d.simul_ov", i), 32'(ov[i]), 32'd0);
    end
    // second nickel lands while the first still waits behind the long gap of u1
    do_reset();
    repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (14) tick(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("u1.ovr_dcount", cnt_d[1], 1);
    chk("u1.ovr_ncount", cnt_n[1], 1);
    chk("u1.ovr_nedge", first_n[1], 14);
    chk("u1.ovr_set", 32'(ov[1]), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("u1.ovr_clr", 32'(ov[1]), 32'd0);
    // dime held through reset gives one pulse after release
    repeat (3) tick(1'b1, 1'b0, 1'b1, 1'b0);
    clr_stats();
    repeat (15) tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.rst_hold_latency", i), first_d[i], DEB[i] + 3);
      chk($sformatf("u%0d.rst_hold_count", i), cnt_d[i], 1);
    end
    // reset while nickel is pending discards it
    do_reset();
    repeat (6) tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("u0.pend_busy", 32'(bz[0]), 32'd1);
    clr_stats();
    repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("u0.midrst_ncount", cnt_n[0], 0);
    chk("u0.midrst_busy", 32'(bz[0]), 32'd0);
    // random levels with random hold times, occasional clears and resets
    do_reset();
    rd = 1'b0; rn = 1'b0; hd = 1; hn = 1;
    repeat (1500) begin
      if (--hd == 0) begin rd = !rd; hd = $urandom_range(1, 12); end
      if (--hn == 0) begin rn = !rn; hn = $urandom_range(1, 12); end
      tick(rd, rn, $urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end
endmodule
